// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational comparator among NREQ requesters.
// Each transaction takes exactly three cycles: grant/operand capture, result capture,
// then a one-cycle done pulse during which the grant is still held.
module cmp_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned CNTW = 16,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      cmp_a,
    output logic [W-1:0]      cmp_b,
    input  logic              cmp_l,
    input  logic              cmp_e,
    input  logic              cmp_g,
    output logic              done,
    output logic [IDW-1:0]    res_id,
    output logic              res_lt,
    output logic              res_eq,
    output logic              res_gt,
    output logic              res_err,
    output logic [CNTW-1:0]   n_done
);

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;
    logic           lge_one_hot;
    logic [IDW-1:0] next_ptr;

    // Winner search: first requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win   = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Comparator health: exactly one of l/e/g must be asserted.
    always_comb begin
        lge_one_hot = (cmp_l ^ cmp_e ^ cmp_g) & ~(cmp_l & cmp_e & cmp_g);
        next_ptr    = (res_id == IDW'(NREQ - 1)) ? '0 : res_id + IDW'(1);
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            rr_ptr  <= '0;
            gnt     <= '0;
            cmp_a   <= '0;
            cmp_b   <= '0;
            done    <= 1'b0;
            res_id  <= '0;
            res_lt  <= 1'b0;
            res_eq  <= 1'b0;
            res_gt  <= 1'b0;
            res_err <= 1'b0;
            n_done  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|req) begin
                        gnt    <= NREQ'(1) << win;
                        cmp_a  <= a_in[win*W +: W];
                        cmp_b  <= b_in[win*W +: W];
                        res_id <= win;
                        state  <= StCmp;
                    end
                end
                StCmp: begin
                    res_lt  <= cmp_l;
                    res_eq  <= cmp_e;
                    res_gt  <= cmp_g;
                    res_err <= ~lge_one_hot;
                    done    <= 1'b1;
                    state   <= StResp;
                end
                StResp: begin
                    done   <= 1'b0;
                    gnt    <= '0;
                    // Pointer moves only on completion so a lone requester keeps winning.
                    rr_ptr <= next_ptr;
                    n_done <= n_done + CNTW'(1);
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
